// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port async-read RAM between requester A (CPU) and B (display fetch)
//   clock, reset             : sole clock, synchronous active-high reset
//   a_req/a_wr/a_addr/a_din  : A request, held stable until a_ack
//   a_ack                    : comb, A's access is on the RAM this cycle
//   a_rvalid/a_dout          : registered read pulse and held read data for A
//   b_*                      : same set for requester B
//   ram_wr/ram_addr/ram_din  : drive the RAM; zero when idle
//   ram_dout                 : async RAM read data
module ram_arbiter #(
   parameter int Nloc    = 16,
   parameter int Dbits   = 4,
   parameter int PRIO_A  = 0,
   parameter int MAXWAIT = 7,
   localparam int AW     = $clog2(Nloc)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             a_req,
   input  logic             a_wr,
   input  logic [AW-1:0]    a_addr,
   input  logic [Dbits-1:0] a_din,
   output logic             a_ack,
   output logic             a_rvalid,
   output logic [Dbits-1:0] a_dout,
   input  logic             b_req,
   input  logic             b_wr,
   input  logic [AW-1:0]    b_addr,
   input  logic [Dbits-1:0] b_din,
   output logic             b_ack,
   output logic             b_rvalid,
   output logic [Dbits-1:0] b_dout,
   output logic             ram_wr,
   output logic [AW-1:0]    ram_addr,
   output logic [Dbits-1:0] ram_din,
   input  logic [Dbits-1:0] ram_dout
);
   localparam int BW = $clog2(MAXWAIT + 1);
   localparam logic [BW-1:0] MW = BW'(MAXWAIT);
   logic          last;
   logic [BW-1:0] bwait;
   logic          gnt_a, gnt_b;
   // B wins a tie when it is its turn (round-robin) or it has starved MAXWAIT cycles (A-priority)
   always_comb begin
      gnt_b    = b_req && (!a_req || ((PRIO_A != 0) ? (bwait == MW) : !last));
      gnt_a    = a_req && !gnt_b;
      a_ack    = gnt_a;
      b_ack    = gnt_b;
      ram_wr   = gnt_a ? a_wr   : gnt_b ? b_wr   : 1'b0;
      ram_addr = gnt_a ? a_addr : gnt_b ? b_addr : '0;
      ram_din  = gnt_a ? a_din  : gnt_b ? b_din  : '0;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         last     <= 1'b1;
         bwait    <= '0;
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_dout   <= '0;
         b_dout   <= '0;
      end else begin
         if (gnt_a || gnt_b) last <= gnt_b;
         a_rvalid <= gnt_a && !a_wr;
         b_rvalid <= gnt_b && !b_wr;
         if (gnt_a && !a_wr) a_dout <= ram_dout;
         if (gnt_b && !b_wr) b_dout <= ram_dout;
         bwait <= (PRIO_A == 0 || !b_req || gnt_b) ? '0 : (bwait == MW) ? MW : bwait + 1'b1;
      end
   end
endmodule
